// File: rtl/cook_sequencer_pkg.sv
// Shared types for the microwave cook sequencer: FSM state codes and the
// four-digit MM:SS BCD time word.
package cook_sequencer_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // [3]=min_tens [2]=min_ones [1]=sec_tens [0]=sec_ones
    typedef logic [3:0][DIGIT_W-1:0] mmss_t;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/cook_sequencer_bcd_mmss_down.sv
// MM:SS BCD time register: shift-in keypad load, borrow-chained countdown,
// clear, and zero / one flags for the sequencer FSM.
module bcd_mmss_down
    import cook_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_i,
    input  logic               load_i,
    input  logic [DIGIT_W-1:0] digit_i,
    input  logic               dec_i,
    output mmss_t              digits_o,
    output logic               zero_o,
    output logic               one_o
);

    mmss_t digits_q, digits_d, dec_v;

    // Seconds tens borrow to 5 so 1:00 -> 0:59; entered seconds >59 still count down.
    always_comb begin
        dec_v = digits_q;
        if (digits_q[0] != 4'd0) begin
            dec_v[0] = digits_q[0] - 4'd1;
        end else begin
            dec_v[0] = 4'd9;
            if (digits_q[1] != 4'd0) begin
                dec_v[1] = digits_q[1] - 4'd1;
            end else begin
                dec_v[1] = 4'd5;
                if (digits_q[2] != 4'd0) begin
                    dec_v[2] = digits_q[2] - 4'd1;
                end else begin
                    dec_v[2] = 4'd9;
                    dec_v[3] = digits_q[3] - 4'd1;
                end
            end
        end
    end

    assign zero_o = (digits_q == '0);
    assign one_o  = (digits_q == mmss_t'(16'h0001));

    always_comb begin
        digits_d = digits_q;
        if (clr_i)
            digits_d = '0;
        else if (load_i)
            digits_d = {digits_q[2:0], digit_i};
        else if (dec_i && !zero_o)
            digits_d = dec_v;
    end

    always_ff @(posedge clk) begin
        if (reset)
            digits_q <= '0;
        else
            digits_q <= digits_d;
    end

    assign digits_o = digits_q;

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: keypad time entry, 1 Hz countdown, pause on
// door/stop, magnetron enable and end-of-cook beep.
module cook_sequencer
    import cook_sequencer_pkg::*;
#(
    parameter int BEEP_TICKS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_1hz,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               startn,
    input  logic               stopn,
    input  logic               clearn,
    input  logic               door_closed,
    output logic               mag_on,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               beep,
    output logic [2:0]         state
);

    state_e     state_q;
    logic       mag_q, beep_q;
    logic [3:0] beep_cnt_q;

    mmss_t digits;
    logic  zero, one;
    logic  start_ok, halt, key_ok;
    logic  clr, load, dec;

    assign start_ok = !startn && door_closed && stopn && !zero;
    assign halt     = !door_closed || !stopn;
    assign key_ok   = key_valid && is_bcd(key_digit);

    // A halting input on the final tick wins: no decrement is applied.
    always_comb begin
        clr  = 1'b0;
        load = 1'b0;
        dec  = 1'b0;
        if (!clearn) begin
            clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: load = key_ok;
                ST_SET:  load = key_ok && !start_ok;
                ST_COOK: dec  = tick_1hz && !halt && !zero;
                default: ;
            endcase
        end
    end

    bcd_mmss_down u_time (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (clr),
        .load_i   (load),
        .digit_i  (key_digit),
        .dec_i    (dec),
        .digits_o (digits),
        .zero_o   (zero),
        .one_o    (one)
    );

    always_ff @(posedge clk) begin
        if (reset || !clearn) begin
            state_q    <= ST_IDLE;
            mag_q      <= 1'b0;
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_ok)
                        state_q <= ST_SET;
                end
                ST_SET, ST_PAUSE: begin
                    if (start_ok) begin
                        state_q <= ST_COOK;
                        mag_q   <= 1'b1;
                    end
                end
                ST_COOK: begin
                    if (halt) begin
                        state_q <= ST_PAUSE;
                        mag_q   <= 1'b0;
                    end else if (zero || (tick_1hz && one)) begin
                        state_q    <= ST_DONE;
                        mag_q      <= 1'b0;
                        beep_q     <= 1'b1;
                        beep_cnt_q <= '0;
                    end
                end
                ST_DONE: begin
                    if (tick_1hz) begin
                        if (beep_cnt_q == 4'(BEEP_TICKS - 1)) begin
                            state_q    <= ST_IDLE;
                            beep_q     <= 1'b0;
                            beep_cnt_q <= '0;
                        end else begin
                            beep_cnt_q <= beep_cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    mag_q   <= 1'b0;
                    beep_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mag_on   = mag_q;
    assign beep     = beep_q;
    assign state    = state_q;
    assign min_tens = digits[3];
    assign min_ones = digits[2];
    assign sec_tens = digits[1];
    assign sec_ones = digits[0];

endmodule

// File: tb/tb_cook_sequencer.sv
// Bench for cook_sequencer: directed scenarios against constants, then
// randomized traffic against a minutes/seconds arithmetic reference model.
module tb_cook_sequencer;

    localparam int BEEP = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1, tick_1hz = 1'b0, key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       startn = 1'b1, stopn = 1'b1, clearn = 1'b1, door_closed = 1'b1;
    logic       mag_on, beep;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] state;

    int checks = 0, errors = 0;

    // Reference model: state code, minutes 0..99, seconds field 0..99.
    int m_state = 0, mm = 0, ss = 0, m_cnt = 0;
    logic m_mag = 1'b0, m_beep = 1'b0;

    wire [20:0] obs = {state, mag_on, beep, min_tens, min_ones, sec_tens, sec_ones};

    cook_sequencer #(.BEEP_TICKS(BEEP)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .key_valid(key_valid),
        .key_digit(key_digit), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .mag_on(mag_on), .min_tens(min_tens),
        .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .beep(beep), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] model_exp();
        return {3'(m_state), m_mag, m_beep, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic void model_update();
        bit tz, start_ok, halt, key_ok;
        int v;
        if (reset || !clearn) begin
            m_state = 0; m_cnt = 0;
            if (reset || !clearn) begin mm = 0; ss = 0; end
        end else begin
            tz       = (mm == 0) && (ss == 0);
            start_ok = !startn && door_closed && stopn && !tz;
            halt     = !door_closed || !stopn;
            key_ok   = key_valid && (key_digit <= 9);
            if (((m_state == 0) || (m_state == 1 && !start_ok)) && key_ok) begin
                v  = ((mm * 100 + ss) * 10 + int'(key_digit)) % 10000;
                mm = v / 100; ss = v % 100;
            end
            case (m_state)
                0: if (key_ok) m_state = 1;
                1, 3: if (start_ok) m_state = 2;
                2: begin
                    if (halt) m_state = 3;
                    else if (tz) begin m_state = 4; m_cnt = 0; end
                    else if (tick_1hz) begin
                        if (ss > 0) ss--; else begin ss = 59; mm--; end
                        if (mm == 0 && ss == 0) begin m_state = 4; m_cnt = 0; end
                    end
                end
                4: if (tick_1hz) begin
                    m_cnt++;
                    if (m_cnt == BEEP) begin m_state = 0; m_cnt = 0; end
                end
                default: m_state = 0;
            endcase
        end
        m_mag  = (m_state == 2);
        m_beep = (m_state == 4);
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic press_key(input logic [3:0] d);
        key_valid = 1'b1; key_digit = d; step();
        key_valid = 1'b0; step();
    endtask

    task automatic tick();
        tick_1hz = 1'b1; step();
        tick_1hz = 1'b0; step();
    endtask

    task automatic start_pulse();
        startn = 1'b0; step();
        startn = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step();
        reset = 1'b0; step();
        checks++;
        if (obs !== 21'h0) begin
            errors++; $display("FAIL reset obs=%h exp=%h", obs, 21'h0);
        end
    endtask

    task automatic test_keys_and_cook();
        press_key(4'd1); press_key(4'd3); press_key(4'd0);
        checks++;
        if (obs !== {3'd1, 2'b00, 16'h0130}) begin
            errors++; $display("FAIL keys_0130 obs=%h exp=%h", obs, {3'd1, 2'b00, 16'h0130});
        end
        press_key(4'd12);
        checks++;
        if (obs !== {3'd1, 2'b00, 16'h0130}) begin
            errors++; $display("FAIL key12_ignored obs=%h exp=%h", obs, {3'd1, 2'b00, 16'h0130});
        end
        door_closed = 1'b0; start_pulse(); door_closed = 1'b1;
        checks++;
        if (obs !== {3'd1, 2'b00, 16'h0130}) begin
            errors++; $display("FAIL start_door_open obs=%h exp=%h", obs, {3'd1, 2'b00, 16'h0130});
        end
        start_pulse();
        checks++;
        if (obs !== {3'd2, 2'b10, 16'h0130}) begin
            errors++; $display("FAIL start_cook obs=%h exp=%h", obs, {3'd2, 2'b10, 16'h0130});
        end
        press_key(4'd5);
        tick();
        checks++;
        if (obs !== {3'd2, 2'b10, 16'h0129}) begin
            errors++; $display("FAIL tick_0129 obs=%h exp=%h", obs, {3'd2, 2'b10, 16'h0129});
        end
        repeat (29) tick();
        checks++;
        if (obs !== {3'd2, 2'b10, 16'h0100}) begin
            errors++; $display("FAIL tick_0100 obs=%h exp=%h", obs, {3'd2, 2'b10, 16'h0100});
        end
        tick();
        checks++;
        if (obs !== {3'd2, 2'b10, 16'h0059}) begin
            errors++; $display("FAIL borrow_0059 obs=%h exp=%h", obs, {3'd2, 2'b10, 16'h0059});
        end
        clearn = 1'b0; step(); clearn = 1'b1;
        checks++;
        if (obs !== 21'h0) begin
            errors++; $display("FAIL clear_cook obs=%h exp=%h", obs, 21'h0);
        end
    endtask

    task automatic test_pause_done();
        press_key(4'd2); start_pulse(); tick();
        door_closed = 1'b0; step();
        checks++;
        if (obs !== {3'd3, 2'b00, 16'h0001}) begin
            errors++; $display("FAIL door_pause obs=%h exp=%h", obs, {3'd3, 2'b00, 16'h0001});
        end
        tick(); door_closed = 1'b1; step();
        checks++;
        if (obs !== {3'd3, 2'b00, 16'h0001}) begin
            errors++; $display("FAIL pause_tick_hold obs=%h exp=%h", obs, {3'd3, 2'b00, 16'h0001});
        end
        start_pulse(); tick();
        checks++;
        if (obs !== {3'd4, 2'b01, 16'h0000}) begin
            errors++; $display("FAIL done_entry obs=%h exp=%h", obs, {3'd4, 2'b01, 16'h0000});
        end
        start_pulse(); tick(); tick();
        checks++;
        if (obs !== {3'd4, 2'b01, 16'h0000}) begin
            errors++; $display("FAIL done_two_ticks obs=%h exp=%h", obs, {3'd4, 2'b01, 16'h0000});
        end
        tick();
        checks++;
        if (obs !== 21'h0) begin
            errors++; $display("FAIL done_to_idle obs=%h exp=%h", obs, 21'h0);
        end
    endtask

    task automatic test_zero_start();
        start_pulse();
        checks++;
        if (obs !== 21'h0) begin
            errors++; $display("FAIL idle_start obs=%h exp=%h", obs, 21'h0);
        end
        press_key(4'd0); start_pulse();
        checks++;
        if (obs !== {3'd1, 2'b00, 16'h0000}) begin
            errors++; $display("FAIL zero_start obs=%h exp=%h", obs, {3'd1, 2'b00, 16'h0000});
        end
        clearn = 1'b0; step(); clearn = 1'b1;
    endtask

    task automatic test_abort();
        press_key(4'd4); press_key(4'd5); start_pulse();
        reset = 1'b1; step(); reset = 1'b0;
        checks++;
        if (obs !== 21'h0) begin
            errors++; $display("FAIL reset_mid_cook obs=%h exp=%h", obs, 21'h0);
        end
        press_key(4'd1); start_pulse();
        door_closed = 1'b0; tick_1hz = 1'b1; step();
        tick_1hz = 1'b0; door_closed = 1'b1;
        checks++;
        if (obs !== {3'd3, 2'b00, 16'h0001}) begin
            errors++; $display("FAIL final_tick_pause obs=%h exp=%h", obs, {3'd3, 2'b00, 16'h0001});
        end
        clearn = 1'b0; step(); clearn = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(0, 499) == 0);
            clearn      = ($urandom_range(0, 149) != 0);
            tick_1hz    = ($urandom_range(0, 2) == 0);
            key_valid   = ($urandom_range(0, 5) == 0);
            key_digit   = 4'($urandom_range(0, 15));
            startn      = ($urandom_range(0, 9) != 0);
            stopn       = ($urandom_range(0, 29) != 0);
            door_closed = ($urandom_range(0, 24) != 0);
            step();
            checks++;
            if (obs !== model_exp()) begin
                errors++; $display("FAIL random[%0d] obs=%h exp=%h", i, obs, model_exp());
            end
        end
    endtask

    initial begin
        test_reset();
        test_keys_and_cook();
        test_pause_done();
        test_zero_start();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
